// File: rtl/if_fetch_unit_if.sv
// Instruction-cache read port shared between the fetch stage (master) and the cache (slave).
// One request stays asserted until the cache answers with a single i_ready pulse.
interface if_fetch_unit_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_readM;
    logic [WORD_SIZE-1:0] i_address;
    logic [WORD_SIZE-1:0] i_data;
    logic                 i_ready;

    modport master (
        output i_readM,
        output i_address,
        input  i_data,
        input  i_ready
    );

    modport slave (
        input  i_readM,
        input  i_address,
        output i_data,
        output i_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues I-cache reads, consults the
// combinational predictor and fills the IF/ID register, absorbing stalls and redirects.
module if_fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    if_fetch_unit_if.master      icache,
    output logic [WORD_SIZE-1:0] pred_PC,
    output logic [WORD_SIZE-1:0] pred_instr,
    input  logic [WORD_SIZE-1:0] pred_nextPC,
    input  logic                 stall,
    input  logic                 forcePC,
    input  logic [WORD_SIZE-1:0] forcePCdata,
    output logic                 IF_ID_valid,
    output logic [WORD_SIZE-1:0] IF_ID_PC,
    output logic [WORD_SIZE-1:0] IF_ID_instr,
    output logic [WORD_SIZE-1:0] IF_ID_nextPC,
    output logic [15:0]          fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t               state, state_next;
    logic [WORD_SIZE-1:0] pc, pc_next;
    logic [WORD_SIZE-1:0] redirect_pc, redirect_pc_next;
    logic [WORD_SIZE-1:0] hold_instr, hold_instr_next;
    logic [WORD_SIZE-1:0] hold_next_pc, hold_next_pc_next;
    logic                 valid_next;
    logic [WORD_SIZE-1:0] id_pc_next, id_instr_next, id_next_pc_next;
    logic [15:0]          count_next;

    // A request stays on the bus in DRAIN so the cache is never left with an orphaned read.
    assign icache.i_readM   = (state == REQ) || (state == DRAIN);
    assign icache.i_address = pc;
    assign pred_PC          = pc;
    assign pred_instr       = icache.i_data;

    // NOTE: every variable driven here gets its hold value first, so no path infers a latch.
    always_comb begin
        state_next        = state;
        pc_next           = pc;
        redirect_pc_next  = redirect_pc;
        hold_instr_next   = hold_instr;
        hold_next_pc_next = hold_next_pc;
        valid_next        = IF_ID_valid;
        id_pc_next        = IF_ID_PC;
        id_instr_next     = IF_ID_instr;
        id_next_pc_next   = IF_ID_nextPC;
        count_next        = fetch_count;

        unique case (state)
            IDLE: state_next = REQ;

            REQ: begin
                if (forcePC) begin
                    valid_next = 1'b0;
                    if (icache.i_ready) begin
                        pc_next = forcePCdata;
                    end else begin
                        // PC keeps the in-flight address until the drain completes.
                        redirect_pc_next = forcePCdata;
                        state_next       = DRAIN;
                    end
                end else if (icache.i_ready && !stall) begin
                    valid_next      = 1'b1;
                    id_pc_next      = pc;
                    id_instr_next   = icache.i_data;
                    id_next_pc_next = pred_nextPC;
                    pc_next         = pred_nextPC;
                    count_next      = fetch_count + 16'd1;
                end else if (icache.i_ready) begin
                    hold_instr_next   = icache.i_data;
                    hold_next_pc_next = pred_nextPC;
                    state_next        = HOLD;
                end else if (!stall) begin
                    valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (forcePC) begin
                    valid_next        = 1'b0;
                    hold_instr_next   = '0;
                    hold_next_pc_next = '0;
                    pc_next           = forcePCdata;
                    state_next        = REQ;
                end else if (!stall) begin
                    valid_next      = 1'b1;
                    id_pc_next      = pc;
                    id_instr_next   = hold_instr;
                    id_next_pc_next = hold_next_pc;
                    pc_next         = hold_next_pc;
                    count_next      = fetch_count + 16'd1;
                    state_next      = REQ;
                end
            end

            DRAIN: begin
                valid_next = 1'b0;
                if (icache.i_ready) begin
                    pc_next    = forcePC ? forcePCdata : redirect_pc;
                    state_next = REQ;
                end else if (forcePC) begin
                    redirect_pc_next = forcePCdata;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            redirect_pc  <= '0;
            hold_instr   <= '0;
            hold_next_pc <= '0;
            IF_ID_valid  <= 1'b0;
            IF_ID_PC     <= '0;
            IF_ID_instr  <= '0;
            IF_ID_nextPC <= '0;
            fetch_count  <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            redirect_pc  <= redirect_pc_next;
            hold_instr   <= hold_instr_next;
            hold_next_pc <= hold_next_pc_next;
            IF_ID_valid  <= valid_next;
            IF_ID_PC     <= id_pc_next;
            IF_ID_instr  <= id_instr_next;
            IF_ID_nextPC <= id_next_pc_next;
            fetch_count  <= count_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a latency-programmable cache model and a tiny
// jump-decoding predictor drive the stage; every check compares against hand-derived values.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pred_PC, pred_instr, pred_nextPC;
    logic        stall, forcePC;
    logic [15:0] forcePCdata;
    logic        IF_ID_valid;
    logic [15:0] IF_ID_PC, IF_ID_instr, IF_ID_nextPC, fetch_count;

    int n_checks = 0;
    int n_bad    = 0;
    int lat      = 1;
    int wait_cnt = 0;

    if_fetch_unit_if #(.WORD_SIZE(16)) bus ();

    if_fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .icache       (bus.master),
        .pred_PC      (pred_PC),
        .pred_instr   (pred_instr),
        .pred_nextPC  (pred_nextPC),
        .stall        (stall),
        .forcePC      (forcePC),
        .forcePCdata  (forcePCdata),
        .IF_ID_valid  (IF_ID_valid),
        .IF_ID_PC     (IF_ID_PC),
        .IF_ID_instr  (IF_ID_instr),
        .IF_ID_nextPC (IF_ID_nextPC),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    // Program image: 0x0010 holds JMP 0x0A20 (top nibble F), everything else is {1, addr[11:0]}.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hFA20 : {4'h1, a[11:0]};
    endfunction

    // Cache answers on the lat-th cycle the request is visible.
    assign bus.i_ready = bus.i_readM && (wait_cnt == lat - 1);
    assign bus.i_data  = bus.i_ready ? mem_word(bus.i_address) : 16'hDEAD;

    always_ff @(posedge clk) begin
        if (reset_n)
            wait_cnt <= 0;
        else if (bus.i_readM)
            wait_cnt <= bus.i_ready ? 0 : wait_cnt + 1;
    end

    assign pred_nextPC = (pred_instr[15:12] == 4'hF) ? {4'h0, pred_instr[11:0]} : pred_PC + 16'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        reset_n     = 1'b1;
        stall       = 1'b0;
        forcePC     = 1'b0;
        forcePCdata = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_readM", 32'(bus.i_readM), 32'h0);
        check("rst_valid", 32'(IF_ID_valid), 32'h0);
        check("rst_count", 32'(fetch_count), 32'h0);
        check("rst_id_pc", 32'(IF_ID_PC), 32'h0);
        check("rst_addr", 32'(bus.i_address), 32'h0);
        reset_n = 1'b0;

        @(negedge clk);
        check("first_req", 32'(bus.i_readM), 32'h1);
        check("first_addr", 32'(bus.i_address), 32'h0);

        // Latency 1: PCs 0..0x10 enter IF/ID on consecutive cycles; 0x10 is the jump.
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            check("seq_valid", 32'(IF_ID_valid), 32'h1);
            check("seq_pc", 32'(IF_ID_PC), 32'(i));
            check("seq_instr", 32'(IF_ID_instr), (i == 16) ? 32'hFA20 : 32'h1000 + 32'(i));
            check("seq_npc", 32'(IF_ID_nextPC), (i == 16) ? 32'h0A20 : 32'(i + 1));
            if (i == 3) check("seq_count4", 32'(fetch_count), 32'h4);
        end
        check("jmp_addr", 32'(bus.i_address), 32'h0A20);
        check("jmp_readM", 32'(bus.i_readM), 32'h1);
        @(negedge clk);
        check("jmp_no_bubble", 32'(IF_ID_PC), 32'h0A20);
        check("jmp_valid", 32'(IF_ID_valid), 32'h1);
        check("jmp_count", 32'(fetch_count), 32'h12);

        // Latency 3 with stall high over the arrival: miss wait, then HOLD, then release.
        lat   = 3;
        stall = 1'b1;
        @(negedge clk);
        check("miss_stall_valid", 32'(IF_ID_valid), 32'h1);
        check("miss_stall_pc", 32'(IF_ID_PC), 32'h0A20);
        @(negedge clk);
        @(negedge clk);
        check("hold_readM", 32'(bus.i_readM), 32'h0);
        check("hold_id_pc", 32'(IF_ID_PC), 32'h0A20);
        check("hold_count", 32'(fetch_count), 32'h12);
        @(negedge clk);
        check("hold2_readM", 32'(bus.i_readM), 32'h0);
        check("hold2_count", 32'(fetch_count), 32'h12);
        stall = 1'b0;
        @(negedge clk);
        check("rel_pc", 32'(IF_ID_PC), 32'h0A21);
        check("rel_instr", 32'(IF_ID_instr), 32'h1A21);
        check("rel_npc", 32'(IF_ID_nextPC), 32'h0A22);
        check("rel_count", 32'(fetch_count), 32'h13);
        check("rel_addr", 32'(bus.i_address), 32'h0A22);
        @(negedge clk);
        check("miss_bubble", 32'(IF_ID_valid), 32'h0);

        // Redirect during a miss at 0x0A22 -> drain, then land on 0x0005.
        forcePC     = 1'b1;
        forcePCdata = 16'h0005;
        @(negedge clk);
        forcePC = 1'b0;
        check("drain1_addr", 32'(bus.i_address), 32'h0A22);
        check("drain1_readM", 32'(bus.i_readM), 32'h1);
        @(negedge clk);
        check("redir1_addr", 32'(bus.i_address), 32'h0005);

        // Redirect to 0x0040 while the 0x0005 miss is outstanding.
        forcePC     = 1'b1;
        forcePCdata = 16'h0040;
        @(negedge clk);
        forcePC = 1'b0;
        check("drain2_addr", 32'(bus.i_address), 32'h0005);
        check("drain2_readM", 32'(bus.i_readM), 32'h1);
        check("drain2_valid", 32'(IF_ID_valid), 32'h0);
        @(negedge clk);
        check("drain2b_addr", 32'(bus.i_address), 32'h0005);
        check("drain2b_valid", 32'(IF_ID_valid), 32'h0);
        @(negedge clk);
        check("redir2_addr", 32'(bus.i_address), 32'h0040);
        check("redir2_valid", 32'(IF_ID_valid), 32'h0);
        check("redir2_count", 32'(fetch_count), 32'h13);

        // forcePC coincides with i_ready: the returned word is dropped.
        lat         = 1;
        forcePC     = 1'b1;
        forcePCdata = 16'h0100;
        @(negedge clk);
        forcePC = 1'b0;
        check("samecyc_addr", 32'(bus.i_address), 32'h0100);
        check("samecyc_valid", 32'(IF_ID_valid), 32'h0);
        check("samecyc_count", 32'(fetch_count), 32'h13);
        @(negedge clk);
        check("tgt_pc", 32'(IF_ID_PC), 32'h0100);
        check("tgt_instr", 32'(IF_ID_instr), 32'h1100);
        check("tgt_count", 32'(fetch_count), 32'h14);

        // Free-run at one fetch per cycle until the counter wraps.
        repeat (65515) @(negedge clk);
        check("count_max", 32'(fetch_count), 32'hFFFF);
        @(negedge clk);
        check("count_wrap", 32'(fetch_count), 32'h0);
        check("wrap_valid", 32'(IF_ID_valid), 32'h1);

        // Enter HOLD, then reset from there.
        lat   = 2;
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hold3_readM", 32'(bus.i_readM), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_readM", 32'(bus.i_readM), 32'h0);
        check("mid_rst_valid", 32'(IF_ID_valid), 32'h0);
        check("mid_rst_pc", 32'(IF_ID_PC), 32'h0);
        check("mid_rst_instr", 32'(IF_ID_instr), 32'h0);
        check("mid_rst_npc", 32'(IF_ID_nextPC), 32'h0);
        check("mid_rst_count", 32'(fetch_count), 32'h0);
        check("mid_rst_addr", 32'(bus.i_address), 32'h0);
        reset_n = 1'b0;
        stall   = 1'b0;
        lat     = 1;
        @(negedge clk);
        check("post_rst_readM", 32'(bus.i_readM), 32'h1);
        check("post_rst_addr", 32'(bus.i_address), 32'h0);
        @(negedge clk);
        check("post_rst_pc", 32'(IF_ID_PC), 32'h0);
        check("post_rst_valid", 32'(IF_ID_valid), 32'h1);
        check("post_rst_count", 32'(fetch_count), 32'h1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
